// File: rtl/h80_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// h80_uart_pkg
// Shared types and helpers for the h80 UART transmit back-end.
//   uart_tx_state_t : transmitter FSM states (PARITY only reached when the
//                     H80_UART_TX_PARITY_EN build option is defined)
//   UART_DATA_BITS  : data bits per frame
//   uart_div()      : baud divisor rounded to nearest
// -----------------------------------------------------------------------------
package h80_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int uart_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/h80_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// h80_uart_tx_fifo
// Single-clock byte FIFO feeding the UART serializer.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   push, wr_data  : write strobe and byte; ignored while full
//   pop            : read strobe; ignored while empty
//   rd_data        : head entry (valid while empty=0)
//   full, empty    : registered occupancy flags
//   level          : registered occupancy count
// -----------------------------------------------------------------------------
module h80_uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [7:0]                    wr_data,
    input  logic                          pop,
    output logic [7:0]                    rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("h80_uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [LW-1:0] level_n;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        level_n = level;
        case ({do_push, do_pop})
            2'b10:   level_n = level + 1'b1;
            2'b01:   level_n = level - 1'b1;
            default: level_n = level;
        endcase
    end

    // NOTE: storage array has no reset; only pointers and flags define what
    // is valid, so clearing the data would add reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            // Pointers are exactly PW bits, so they wrap modulo FIFO_DEPTH.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_n;
            full  <= (level_n == LW'(FIFO_DEPTH));
            empty <= (level_n == '0);
        end
    end

endmodule

// File: rtl/h80_uart_tx.sv
// -----------------------------------------------------------------------------
// h80_uart_tx
// Buffered async serial transmitter for the h80 bus IO device. Bytes pushed
// by the IO decoder are queued and sent LSB first as 8N1 frames (8E1 when the
// H80_UART_TX_PARITY_EN macro is defined).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   wr_en        : one-cycle push strobe; wr_data is the byte
//   clr_ovf      : one-cycle pulse clearing ovf (a coincident drop wins)
//   full, empty  : FIFO occupancy flags
//   busy         : frame on the line or bytes still queued
//   level        : FIFO occupancy
//   ovf          : sticky, a push arrived while full and was dropped
//   uart_txp     : serial line, idles high, driven from a flop
// -----------------------------------------------------------------------------
module h80_uart_tx
    import h80_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          clr_ovf,
    output logic                          full,
    output logic                          empty,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    output logic                          uart_txp
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("h80_uart_tx: baud divisor must be at least 2");
    end

    uart_tx_state_t state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     idx, idx_n;
    logic [7:0]     shift, shift_n;
    logic           txp_n;
    logic           ovf_n;
    logic           pop;
    logic [7:0]     rd_data;
    logic           tick;
`ifdef H80_UART_TX_PARITY_EN
    logic           par, par_n;
`endif

    h80_uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign tick = (cnt == '0);
    assign busy = (state != IDLE) || !empty;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        txp_n   = uart_txp;
        pop     = 1'b0;
`ifdef H80_UART_TX_PARITY_EN
        par_n   = par;
`endif

        // Set wins over clear when a dropped push coincides with clr_ovf.
        ovf_n = ovf;
        if (wr_en && full) ovf_n = 1'b1;
        else if (clr_ovf)  ovf_n = 1'b0;

        if (!tick) cnt_n = cnt - 1'b1;

        case (state)
            IDLE: begin
                txp_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = rd_data;
`ifdef H80_UART_TX_PARITY_EN
                    par_n   = ^rd_data;
`endif
                    cnt_n   = DIV_LAST;
                    txp_n   = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_n   = DIV_LAST;
                    idx_n   = '0;
                    txp_n   = shift[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_n = DIV_LAST;
                    if (idx == LAST_BIT) begin
`ifdef H80_UART_TX_PARITY_EN
                        txp_n   = par;
                        state_n = PARITY;
`else
                        txp_n   = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        idx_n   = idx + 1'b1;
                        shift_n = shift >> 1;
                        txp_n   = shift[1];
                    end
                end
            end
`ifdef H80_UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    cnt_n   = DIV_LAST;
                    txp_n   = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    // Chain straight into the next start bit when data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = rd_data;
`ifdef H80_UART_TX_PARITY_EN
                        par_n   = ^rd_data;
`endif
                        cnt_n   = DIV_LAST;
                        txp_n   = 1'b0;
                        state_n = START;
                    end else begin
                        txp_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                txp_n   = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            uart_txp <= 1'b1;
            ovf      <= 1'b0;
`ifdef H80_UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shift    <= shift_n;
            uart_txp <= txp_n;
            ovf      <= ovf_n;
`ifdef H80_UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_h80_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_h80_uart_tx
// Directed bench for h80_uart_tx at CLK_FREQ=1 MHz, BAUD_RATE=100 kbaud
// (10 clocks per bit) with a 4-entry FIFO. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_h80_uart_tx;

    localparam int DIV = 10;
`ifdef H80_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       full;
    logic       empty;
    logic       busy;
    logic [2:0] level;
    logic       ovf;
    logic       uart_txp;

    int checks = 0;
    int errors = 0;

    h80_uart_tx #(
        .CLK_FREQ   (1000000),
        .BAUD_RATE  (100000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .level    (level),
        .ovf      (ovf),
        .uart_txp (uart_txp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after the edge on which the start bit appears; returns just
    // after the edge that ends the stop bit. Each bit is sampled on its first
    // and last clock to pin both its value and its length.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [NB-1:0] bits;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef H80_UART_TX_PARITY_EN
        bits[9]  = ^b;
        bits[10] = 1'b1;
`else
        bits[9]  = 1'b1;
`endif
        for (int k = 0; k < NB; k++) begin
            check($sformatf("%s_bit%0d_first", tag, k), {31'd0, uart_txp}, {31'd0, bits[k]});
            repeat (DIV - 1) step();
            check($sformatf("%s_bit%0d_last", tag, k), {31'd0, uart_txp}, {31'd0, bits[k]});
            step();
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        logic all_high;

        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;

        // ---------------- reset ----------------
        repeat (3) step();
        check("rst_txp",   {31'd0, uart_txp}, 32'd1);
        check("rst_empty", {31'd0, empty},    32'd1);
        check("rst_full",  {31'd0, full},     32'd0);
        check("rst_level", {29'd0, level},    32'd0);
        check("rst_ovf",   {31'd0, ovf},      32'd0);
        check("rst_busy",  {31'd0, busy},     32'd0);
        reset_n = 1'b1;
        all_high = 1'b1;
        repeat (50) begin
            step();
            all_high = all_high & uart_txp;
        end
        check("idle_line_high", {31'd0, all_high}, 32'd1);

        // ---------------- single byte 0x55 ----------------
        push(8'h55);                                 // edge N
        check("single_level_n",  {29'd0, level},    32'd1);
        check("single_empty_n",  {31'd0, empty},    32'd0);
        check("single_busy_n",   {31'd0, busy},     32'd1);
        check("single_txp_n",    {31'd0, uart_txp}, 32'd1);
        step();                                      // edge N+1
        check("single_level_n1", {29'd0, level},    32'd0);
        expect_frame(8'h55, "single");               // ends after N+1+10*NB
        check("single_busy_end", {31'd0, busy},     32'd0);
        check("single_txp_end",  {31'd0, uart_txp}, 32'd1);

        // ---------------- back-to-back 0x41, 0x42 ----------------
        repeat (5) step();
        push(8'h41);                                 // edge M
        check("b2b_level_m",  {29'd0, level}, 32'd1);
        push(8'h42);                                 // edge M+1: push + pop
        check("b2b_level_m1", {29'd0, level}, 32'd1);
        expect_frame(8'h41, "b2b_first");
        check("b2b_level_2nd", {29'd0, level}, 32'd0);
        expect_frame(8'h42, "b2b_second");
        check("b2b_busy_end", {31'd0, busy},  32'd0);

        // ---------------- overflow ----------------
        repeat (5) step();
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i)); // edges P..P+4
        check("ovf_full",      {31'd0, full},  32'd1);
        check("ovf_level4",    {29'd0, level}, 32'd4);
        check("ovf_not_yet",   {31'd0, ovf},   32'd0);
        push(8'h15);                                 // edge P+5, dropped
        check("ovf_set",       {31'd0, ovf},   32'd1);
        check("ovf_level_keep",{29'd0, level}, 32'd4);
        repeat (DIV * NB - 4) step();                // to just after P+1+10*NB
        check("ovf_level3",    {29'd0, level}, 32'd3);
        check("ovf_full_clr",  {31'd0, full},  32'd0);
        for (int i = 1; i < 5; i++) expect_frame(8'h10 + 8'(i), $sformatf("ovf_frame%0d", i));
        check("ovf_idle_busy", {31'd0, busy},  32'd0);
        all_high = 1'b1;
        repeat (30) begin
            step();
            all_high = all_high & uart_txp;
        end
        check("ovf_no_sixth",  {31'd0, all_high}, 32'd1);
        check("ovf_sticky",    {31'd0, ovf},   32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared",   {31'd0, ovf},   32'd0);

        // ---------------- reset mid-frame ----------------
        push(8'h00);                                 // edge R
        step();                                      // edge R+1, start bit
        repeat (44) step();                          // inside data bit 3
        check("midrst_bit3",   {31'd0, uart_txp}, 32'd0);
        reset_n = 1'b0;
        step();
        check("midrst_txp",    {31'd0, uart_txp}, 32'd1);
        check("midrst_empty",  {31'd0, empty},    32'd1);
        check("midrst_busy",   {31'd0, busy},     32'd0);
        reset_n = 1'b1;
        repeat (3) step();
        push(8'h81);
        step();
        expect_frame(8'h81, "after_rst");
        check("after_rst_busy", {31'd0, busy}, 32'd0);

`ifdef H80_UART_TX_PARITY_EN
        // ---------------- parity build ----------------
        push(8'h07);
        step();
        expect_frame(8'h07, "par07");
        check("par07_busy", {31'd0, busy}, 32'd0);
        push(8'h03);
        step();
        expect_frame(8'h03, "par03");
        check("par03_busy", {31'd0, busy}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
